// File: rtl/score_text_renderer.sv
// score_text_renderer: BCD score counter plus a two-stage glyph renderer that
// paints the score as magnified 8x8 digits into a fixed HUD field.
module score_text_renderer #(
  parameter int X0         = 16,
  parameter int Y0         = 16,
  parameter int DIGITS     = 4,
  parameter int SCALE_LOG2 = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_tick,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  video_on,
  input  logic                  score_inc,
  input  logic                  score_clr,
  output logic [3:0]            glyph_char,
  output logic [2:0]            glyph_row,
  input  logic [7:0]            glyph_pixels,
  output logic                  text_on,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic                  overflow
);

  localparam int CW      = 8 << SCALE_LOG2;
  localparam int CH      = 8 << SCALE_LOG2;
  localparam int FIELD_W = DIGITS * CW;

  // Field bounds widened to 11 bits so X0+width never wraps a 10-bit compare.
  localparam logic [10:0] XL = 11'(X0);
  localparam logic [10:0] XH = 11'(X0 + FIELD_W);
  localparam logic [10:0] YL = 11'(Y0);
  localparam logic [10:0] YH = 11'(Y0 + CH);

  // ---------------------------------------------------------------------------
  // Score counter
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0][3:0] score_q, score_d;
  logic                   ovf_q, ovf_d;
  logic                   all_nines;
  logic                   carry;

  // Next score: clear wins, otherwise BCD ripple increment saturating at all-9s.
  always_comb begin
    score_d   = score_q;
    ovf_d     = ovf_q;
    all_nines = 1'b1;
    carry     = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (score_q[i] != 4'd9) all_nines = 1'b0;
    end
    if (score_clr) begin
      score_d = '0;
      ovf_d   = 1'b0;
    end else if (score_inc) begin
      if (all_nines) begin
        ovf_d = 1'b1;
      end else begin
        carry = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (carry) begin
            if (score_q[i] == 4'd9) begin
              score_d[i] = 4'd0;
            end else begin
              score_d[i] = score_q[i] + 4'd1;
              carry      = 1'b0;
            end
          end
        end
      end
    end
  end

  // Score register, updated every clock regardless of pix_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      score_q <= score_d;
      ovf_q   <= ovf_d;
    end
  end

  assign score_bcd = score_q;
  assign overflow  = ovf_q;

  // ---------------------------------------------------------------------------
  // Field geometry and digit selection
  // ---------------------------------------------------------------------------
  logic [10:0]       xe, ye;
  logic              in_field;
  logic [9:0]        rx, ry;
  logic [9:0]        slot;
  logic [2:0]        col, row;
  logic [DIGITS-1:0] lead_zero;
  logic [3:0]        slot_digit;
  logic              blank;
  logic              zero_run;

  assign xe       = {1'b0, x};
  assign ye       = {1'b0, y};
  assign in_field = video_on && (xe >= XL) && (xe < XH) && (ye >= YL) && (ye < YH);
  assign rx       = x - 10'(X0);
  assign ry       = y - 10'(Y0);
  assign slot     = rx >> (3 + SCALE_LOG2);
  assign col      = 3'(rx >> SCALE_LOG2);
  assign row      = 3'(ry >> SCALE_LOG2);

  // lead_zero[i] is set when digit i and every more significant digit are zero.
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      zero_run = zero_run && (score_q[DIGITS-1-i] == 4'd0);
      lead_zero[DIGITS-1-i] = zero_run;
    end
  end

  // Map screen slot to digit (slot 0 = most significant); LS digit never blanks.
  always_comb begin
    slot_digit = 4'd0;
    blank      = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (slot == 10'(DIGITS - 1 - i)) begin
        slot_digit = score_q[i];
        blank      = (i != 0) && lead_zero[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Render pipeline
  // ---------------------------------------------------------------------------
  logic [2:0] col_q;
  logic       vis_q;
  logic       text_q;

  // Stage 1: present glyph code/row to the ROM and remember column/visibility.
  always_ff @(posedge clk) begin
    if (reset) begin
      glyph_char <= '0;
      glyph_row  <= '0;
      col_q      <= '0;
      vis_q      <= 1'b0;
    end else if (pix_tick) begin
      glyph_char <= in_field ? slot_digit : 4'd0;
      glyph_row  <= in_field ? row : 3'd0;
      col_q      <= col;
      vis_q      <= in_field && !blank;
    end
  end

  // Stage 2: pick the addressed bit from the ROM row (bit 7 is leftmost).
  always_ff @(posedge clk) begin
    if (reset) begin
      text_q <= 1'b0;
    end else if (pix_tick) begin
      text_q <= vis_q & glyph_pixels[3'd7 - col_q];
    end
  end

  assign text_on = text_q;

endmodule

// File: tb/tb_score_text_renderer.sv
// Directed self-checking bench for score_text_renderer (default parameters).
module tb_score_text_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_tick;
  logic [9:0]  x, y;
  logic        video_on;
  logic        score_inc, score_clr;
  logic [3:0]  glyph_char;
  logic [2:0]  glyph_row;
  logic [7:0]  glyph_pixels;
  logic        text_on;
  logic [15:0] score_bcd;
  logic        overflow;

  int npass  = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  // Glyph ROM stand-in: a real '7', every other code a solid block so that
  // any blanking failure shows up as a lit pixel.
  function automatic logic [7:0] font(input logic [3:0] c, input logic [2:0] r);
    logic [7:0] seven [8];
    seven = '{8'hFC, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h30, 8'h00};
    return (c == 4'd7) ? seven[r] : 8'hFF;
  endfunction

  assign glyph_pixels = font(glyph_char, glyph_row);

  score_text_renderer #(
    .X0(16), .Y0(16), .DIGITS(4), .SCALE_LOG2(1)
  ) dut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .x(x), .y(y),
    .video_on(video_on), .score_inc(score_inc), .score_clr(score_clr),
    .glyph_char(glyph_char), .glyph_row(glyph_row), .glyph_pixels(glyph_pixels),
    .text_on(text_on), .score_bcd(score_bcd), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic incs(input int n);
    score_inc = 1'b1;
    repeat (n) @(negedge clk);
    score_inc = 1'b0;
  endtask

  task automatic clr();
    score_clr = 1'b1;
    @(negedge clk);
    score_clr = 1'b0;
  endtask

  // Present one pixel, run two ticks, leave the result ready to sample.
  task automatic pix2(input int px, input int py, input logic vo);
    x = 10'(px); y = 10'(py); video_on = vo; pix_tick = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  logic       hist[$];
  logic [3:0] prev_char;
  logic [2:0] prev_row;
  logic       have_prev;
  logic       e_on;
  logic [7:0] frow;
  int         rx, ry, slot, col, row;

  initial begin
    reset = 1'b1; pix_tick = 1'b0; x = '0; y = '0; video_on = 1'b0;
    score_inc = 1'b0; score_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_score", score_bcd, 16'h0000);
    check("rst_ovf", overflow, 0);
    check("rst_char", glyph_char, 0);
    check("rst_row", glyph_row, 0);
    check("rst_text", text_on, 0);
    reset = 1'b0;

    // Test 1
    incs(12);
    check("t1_score", score_bcd, 16'h0012);
    check("t1_ovf", overflow, 0);

    // Test 2
    clr();
    incs(999);
    check("t2_999", score_bcd, 16'h0999);
    incs(1);
    check("t2_ripple", score_bcd, 16'h1000);

    // Test 3
    clr();
    incs(9999);
    check("t3_9999", score_bcd, 16'h9999);
    check("t3_ovf0", overflow, 0);
    incs(1);
    check("t3_sat", score_bcd, 16'h9999);
    check("t3_ovf1", overflow, 1);
    score_inc = 1'b1; score_clr = 1'b1;
    @(negedge clk);
    score_inc = 1'b0; score_clr = 1'b0;
    check("t3_clr_score", score_bcd, 16'h0000);
    check("t3_clr_ovf", overflow, 0);

    // Test 4: score 7, streaming scan with one new pixel per tick
    incs(7);
    check("t4_score", score_bcd, 16'h0007);
    video_on = 1'b1; pix_tick = 1'b1; have_prev = 1'b0;
    for (int py = 16; py < 32; py++) begin
      for (int px = 16; px < 80; px++) begin
        @(negedge clk);
        if (have_prev) begin
          check("t4_char", glyph_char, prev_char);
          check("t4_row", glyph_row, prev_row);
        end
        if (hist.size() == 2) check("t4_text", text_on, hist.pop_front());
        x = 10'(px); y = 10'(py);
        rx = px - 16; ry = py - 16;
        slot = rx / 16; col = (rx / 2) % 8; row = (ry / 2) % 8;
        frow = font(4'd7, 3'(row));
        e_on = (slot == 3) && frow[7 - col];
        prev_char = (slot == 3) ? 4'd7 : 4'd0;
        prev_row = 3'(row);
        have_prev = 1'b1;
        hist.push_back(e_on);
      end
    end
    @(negedge clk);
    check("t4_char", glyph_char, prev_char);
    check("t4_row", glyph_row, prev_row);
    check("t4_text", text_on, hist.pop_front());
    @(negedge clk);
    check("t4_text", text_on, hist.pop_front());
    // Hand-picked boundary pixels of the '7' top bar
    pix2(64, 16, 1'b1); check("t4_x64", text_on, 1);
    pix2(75, 16, 1'b1); check("t4_x75", text_on, 1);
    pix2(76, 16, 1'b1); check("t4_x76", text_on, 0);
    pix2(63, 16, 1'b1); check("t4_x63_blank", text_on, 0);

    // Test 5: stall with pix_tick low
    pix2(64, 16, 1'b1);
    check("t5_pre_text", text_on, 1);
    check("t5_pre_char", glyph_char, 7);
    pix_tick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      x = 10'(66 + i); y = 10'(18 + i);
      @(negedge clk);
      check("t5_hold_char", glyph_char, 7);
      check("t5_hold_row", glyph_row, 0);
      check("t5_hold_text", text_on, 1);
    end
    pix2(66, 18, 1'b1);
    check("t5_row", glyph_row, 1);
    check("t5_text", text_on, 0);
    pix2(74, 18, 1'b1);
    check("t5_text_lit", text_on, 1);

    // Test 6: outside field or video off
    pix2(64, 16, 1'b0);
    check("t6_vo_char", glyph_char, 0);
    check("t6_vo_row", glyph_row, 0);
    check("t6_vo_text", text_on, 0);
    pix2(80, 16, 1'b1);
    check("t6_x80_text", text_on, 0);
    check("t6_x80_char", glyph_char, 0);
    pix2(64, 32, 1'b1);
    check("t6_y32_text", text_on, 0);
    pix2(15, 20, 1'b1);
    check("t6_x15_text", text_on, 0);
    pix2(64, 15, 1'b1);
    check("t6_y15_text", text_on, 0);
    // Reset mid-field
    pix2(64, 16, 1'b1);
    check("t6_lit", text_on, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_text", text_on, 0);
    check("t6_rst_score", score_bcd, 16'h0000);
    reset = 1'b0;
    @(negedge clk);
    check("t6_post1_text", text_on, 0);
    check("t6_post1_char", glyph_char, 0);
    @(negedge clk);
    check("t6_post2_text", text_on, 1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
